// File: rtl/fp_add_arbiter_if.sv
// Bundle of the requester, shared-adder and result signals for fp_add_arbiter.
// The slave modport is the arbiter side; master is the environment side.
interface fp_add_arbiter_if;
    logic        req0_valid;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        req1_ready;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_sum;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_id;
    logic        res_err;
    logic        res_ready;
    logic        busy;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  add_sum, res_ready,
        output req0_ready, req1_ready,
        output add_a, add_b,
        output res_valid, res_data, res_id, res_err, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output add_sum, res_ready,
        input  req0_ready, req1_ready,
        input  add_a, add_b,
        input  res_valid, res_data, res_id, res_err, busy
    );
endinterface

// File: rtl/fp_add_arbiter.sv
// Two-requester round-robin front end for a shared combinational FP adder.
// One operation in flight: accept a pair, hold it on the adder for SETTLE_CYCLES,
// capture the sum, and hold the result until the consumer takes it.
// Pairs with a negative operand or an Inf/NaN exponent are rejected without using the adder.
module fp_add_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter bit          RR_INIT       = 1'b0
) (
    input logic            clk,
    input logic            rst,
    fp_add_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StSettle, StResult} state_e;

    localparam logic [3:0] CntLoad = 4'(SETTLE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        prio_q, prio_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        id_q, id_d;
    logic [31:0] data_q, data_d;
    logic        res_id_q, res_id_d;
    logic        err_q, err_d;

    logic        grant0, grant1, accept, sel_id, sel_bad;
    logic [31:0] sel_a, sel_b;

    function automatic logic is_unsupported(input logic [31:0] x);
        return x[31] | (x[30:23] == 8'hFF);
    endfunction

    // Grant: a lone requester wins; on contention the priority holder wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == StIdle && !rst) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = ~prio_q;
                grant1 = prio_q;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
        accept  = grant0 | grant1;
        sel_id  = grant1;
        sel_a   = grant1 ? bus.req1_a : bus.req0_a;
        sel_b   = grant1 ? bus.req1_b : bus.req0_b;
        sel_bad = is_unsupported(sel_a) | is_unsupported(sel_b);
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prio_d   = prio_q;
        a_d      = a_q;
        b_d      = b_q;
        id_d     = id_q;
        data_d   = data_q;
        res_id_d = res_id_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    a_d    = sel_a;
                    b_d    = sel_b;
                    id_d   = sel_id;
                    prio_d = ~sel_id;
                    if (sel_bad) begin
                        // Rejected pairs bypass the adder entirely.
                        state_d  = StResult;
                        data_d   = 32'h0;
                        err_d    = 1'b1;
                        res_id_d = sel_id;
                    end else begin
                        state_d = StSettle;
                        cnt_d   = CntLoad;
                    end
                end
            end
            StSettle: begin
                if (cnt_q == 4'd0) begin
                    state_d  = StResult;
                    data_d   = bus.add_sum;
                    err_d    = 1'b0;
                    res_id_d = id_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResult: begin
                if (bus.res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            prio_q   <= RR_INIT;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            id_q     <= 1'b0;
            data_q   <= 32'h0;
            res_id_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prio_q   <= prio_d;
            a_q      <= a_d;
            b_q      <= b_d;
            id_q     <= id_d;
            data_q   <= data_d;
            res_id_q <= res_id_d;
            err_q    <= err_d;
        end
    end

    // Output drive.
    always_comb begin
        bus.req0_ready = grant0;
        bus.req1_ready = grant1;
        bus.add_a      = a_q;
        bus.add_b      = b_q;
        bus.res_valid  = (state_q == StResult);
        bus.res_data   = data_q;
        bus.res_id     = res_id_q;
        bus.res_err    = err_q;
        bus.busy       = (state_q != StIdle);
    end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: a transaction-level model checks the SETTLE_CYCLES=1 instance
// every cycle; a second SETTLE_CYCLES=4, RR_INIT=1 instance gets directed literal checks.
module tb_fp_add_arbiter;

    localparam int MSettle = 1;

    logic clk = 1'b0;
    logic rst;
    logic rst4;
    always #5 clk = ~clk;

    fp_add_arbiter_if bus ();
    fp_add_arbiter_if bus4 ();

    fp_add_arbiter #(.SETTLE_CYCLES(1), .RR_INIT(1'b0)) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    fp_add_arbiter #(.SETTLE_CYCLES(4), .RR_INIT(1'b1)) u_dut4 (
        .clk(clk), .rst(rst4), .bus(bus4)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Stand-in for the shared adder: exact for 1.0+1.0, otherwise a distinctive integer mix.
    function automatic logic [31:0] fake_add(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F80_0000 && b == 32'h3F80_0000) return 32'h4000_0000;
        return a + b + 32'h0000_1234;
    endfunction

    function automatic bit bad_operand(input logic [31:0] x);
        return ((x >> 31) != 0) || (((x >> 23) & 32'hFF) == 32'd255);
    endfunction

    always_comb bus.add_sum = fake_add(bus.add_a, bus.add_b);

    // Transaction model: an operation is either absent, waiting m_left edges, or presented.
    bit          m_inflight;
    int          m_left;
    bit          m_prio;
    logic [31:0] m_a, m_b, m_data;
    bit          m_id, m_err, m_pend;
    logic        exp_g0, exp_g1;
    logic [31:0] exp_a, exp_b;

    always_comb begin
        exp_g0 = 1'b0;
        exp_g1 = 1'b0;
        if (!m_inflight && !rst) begin
            if (bus.req0_valid && bus.req1_valid) begin
                exp_g0 = (m_prio == 1'b0);
                exp_g1 = (m_prio == 1'b1);
            end else begin
                exp_g0 = bus.req0_valid;
                exp_g1 = bus.req1_valid;
            end
        end
        exp_a = exp_g1 ? bus.req1_a : bus.req0_a;
        exp_b = exp_g1 ? bus.req1_b : bus.req0_b;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_inflight <= 1'b0;
            m_left     <= 0;
            m_prio     <= 1'b0;
            m_a        <= '0;
            m_b        <= '0;
            m_data     <= '0;
            m_id       <= 1'b0;
            m_err      <= 1'b0;
            m_pend     <= 1'b0;
        end else if (exp_g0 || exp_g1) begin
            m_inflight <= 1'b1;
            m_prio     <= exp_g0;
            m_a        <= exp_a;
            m_b        <= exp_b;
            m_pend     <= exp_g1;
            if (bad_operand(exp_a) || bad_operand(exp_b)) begin
                m_left <= 0;
                m_data <= '0;
                m_err  <= 1'b1;
                m_id   <= exp_g1;
            end else begin
                m_left <= MSettle;
            end
        end else if (m_inflight && m_left > 0) begin
            if (m_left == 1) begin
                m_data <= fake_add(m_a, m_b);
                m_err  <= 1'b0;
                m_id   <= m_pend;
            end
            m_left <= m_left - 1;
        end else if (m_inflight && bus.res_ready) begin
            m_inflight <= 1'b0;
        end
    end

    // Per-cycle comparison of the modelled instance.
    always @(negedge clk) begin
        if (chk_en) begin
            check("req0_ready", bus.req0_ready, exp_g0);
            check("req1_ready", bus.req1_ready, exp_g1);
            check("both_ready", bus.req0_ready & bus.req1_ready, 0);
            check("busy", bus.busy, m_inflight);
            check("res_valid", bus.res_valid, m_inflight && m_left == 0);
            check("res_data", bus.res_data, m_data);
            check("res_id", bus.res_id, m_id);
            check("res_err", bus.res_err, m_err);
            check("add_a", bus.add_a, m_a);
            check("add_b", bus.add_b, m_b);
        end
    end

    int grants[$];
    always @(negedge clk) begin
        if (bus.req0_ready && bus.req0_valid) grants.push_back(0);
        if (bus.req1_ready && bus.req1_valid) grants.push_back(1);
    end

    initial begin
        rst = 1'b1;
        rst4 = 1'b1;
        bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0;
        bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0;
        bus.res_ready = 0;
        bus4.req0_valid = 0; bus4.req0_a = 0; bus4.req0_b = 0;
        bus4.req1_valid = 0; bus4.req1_a = 0; bus4.req1_b = 0;
        bus4.res_ready = 0; bus4.add_sum = 0;

        // Reset state, with a request pending that must not be accepted.
        tick();
        chk_en = 1'b1;
        bus.req0_valid = 1; bus.req0_a = 32'h3F80_0000; bus.req0_b = 32'h3F80_0000;
        #1;
        check("rst_ready0", bus.req0_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.res_valid, 0);
        check("rst_data", bus.res_data, 0);
        check("rst_add_a", bus.add_a, 0);
        tick();
        rst = 1'b0;
        #1 check("r039_ready", bus.req0_ready, 1);

        // 1.0 + 1.0 from requester 0.
        tick();
        bus.req0_valid = 0;
        #1;
        check("r039_busy", bus.busy, 1);
        check("r039_early", bus.res_valid, 0);
        check("r039_add_a", bus.add_a, 32'h3F80_0000);
        tick();
        #1;
        check("r039_valid", bus.res_valid, 1);
        check("r039_data", bus.res_data, 32'h4000_0000);
        check("r039_id", bus.res_id, 0);
        check("r039_err", bus.res_err, 0);
        bus.res_ready = 1;
        tick();
        bus.res_ready = 0;
        #1;
        check("r035_valid", bus.res_valid, 0);
        check("r035_data", bus.res_data, 32'h4000_0000);

        // Negative operand from requester 1 is rejected.
        bus.req1_valid = 1; bus.req1_a = 32'hBF80_0000; bus.req1_b = 32'h3F80_0000;
        #1 check("r041_ready", bus.req1_ready, 1);
        tick();
        bus.req1_valid = 0;
        #1;
        check("r041_valid", bus.res_valid, 1);
        check("r041_err", bus.res_err, 1);
        check("r041_data", bus.res_data, 0);
        check("r041_id", bus.res_id, 1);

        // Back-pressure: result held while both requesters wait.
        bus.req0_valid = 1; bus.req0_a = 32'h3F80_0000; bus.req0_b = 32'h4000_0000;
        bus.req1_valid = 1; bus.req1_a = 32'h4040_0000; bus.req1_b = 32'h4080_0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            check("r042_valid", bus.res_valid, 1);
            check("r042_err", bus.res_err, 1);
            check("r042_id", bus.res_id, 1);
            check("r042_rdy", bus.req0_ready | bus.req1_ready, 0);
            check("r042_busy", bus.busy, 1);
        end

        // Continuous contention alternates grants.
        grants.delete();
        bus.res_ready = 1;
        for (int i = 0; i < 16; i++) tick();
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        for (int i = 0; i < 4; i++) tick();
        bus.res_ready = 0;
        check("r040_count", (grants.size() >= 4) ? 1 : 0, 1);
        if (grants.size() >= 4) begin
            check("r040_g0", grants[0], 0);
            check("r040_g1", grants[1], 1);
            check("r040_g2", grants[2], 0);
            check("r040_g3", grants[3], 1);
        end

        // Reset during SETTLE discards the operation and restores priority.
        bus.req0_valid = 1;
        #1 check("r044_acc", bus.req0_ready, 1);
        tick();
        bus.req0_valid = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("r044_busy", bus.busy, 0);
        check("r044_valid", bus.res_valid, 0);
        bus.req0_valid = 1;
        bus.req1_valid = 1;
        #1;
        check("r044_prio0", bus.req0_ready, 1);
        check("r044_prio1", bus.req1_ready, 0);
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1 check("r044_noresult", bus.res_valid, 0);
        end

        // SETTLE_CYCLES=4 instance: RR_INIT=1 and capture on the 4th settle cycle.
        rst4 = 1'b0;
        bus4.req0_valid = 1; bus4.req0_a = 32'h3F80_0000; bus4.req0_b = 32'h3F80_0000;
        bus4.req1_valid = 1; bus4.req1_a = 32'h4000_0000; bus4.req1_b = 32'h4000_0000;
        #1;
        check("s4_init1", bus4.req1_ready, 1);
        check("s4_init0", bus4.req0_ready, 0);
        tick();
        bus4.req0_valid = 0;
        bus4.req1_valid = 0;
        for (int k = 1; k <= 4; k++) begin
            bus4.add_sum = 32'hA000_0000 + k;
            #1;
            check("s4_wait_valid", bus4.res_valid, 0);
            check("s4_wait_busy", bus4.busy, 1);
            check("s4_add_a", bus4.add_a, 32'h4000_0000);
            tick();
        end
        #1;
        check("s4_valid", bus4.res_valid, 1);
        check("s4_data", bus4.res_data, 32'hA000_0004);
        check("s4_id", bus4.res_id, 1);
        check("s4_err", bus4.res_err, 0);
        bus4.add_sum = 32'hDEAD_0000;
        tick();
        #1;
        check("s4_hold_valid", bus4.res_valid, 1);
        check("s4_hold_data", bus4.res_data, 32'hA000_0004);
        bus4.res_ready = 1;
        tick();
        bus4.res_ready = 0;
        #1;
        check("s4_done_valid", bus4.res_valid, 0);
        check("s4_done_busy", bus4.busy, 0);

        // Requester 1 alone, then reset mid-SETTLE: priority back to RR_INIT=1.
        bus4.req1_valid = 1;
        #1 check("s4_acc1", bus4.req1_ready, 1);
        tick();
        bus4.req1_valid = 0;
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        #1;
        check("s4_rst_busy", bus4.busy, 0);
        check("s4_rst_valid", bus4.res_valid, 0);
        bus4.req0_valid = 1;
        bus4.req1_valid = 1;
        #1;
        check("s4_rst_prio1", bus4.req1_ready, 1);
        check("s4_rst_prio0", bus4.req0_ready, 0);
        bus4.req0_valid = 0;
        bus4.req1_valid = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            #1 check("s4_noresult", bus4.res_valid, 0);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
